// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    // Arbiter FSM: IDLE grants combinationally, BUSY replays the held access.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_e;

    // A simultaneous read and write is treated as a write.
    function automatic op_e decode_op(input logic rd, input logic wr);
        if (wr) begin
            return OP_WR;
        end else if (rd) begin
            return OP_RD;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant: a lone requester wins; on a tie the favoured
// requester wins in round-robin mode, otherwise requester 0 wins.
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio,
    input  logic i_mode,
    output logic o_valid,
    output logic o_gnt
);

    // Grant index: 0 = requester 0, 1 = requester 1.
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_gnt   = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt = i_mode ? i_prio : 1'b0;
        end else if (i_req1) begin
            o_gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory-system port between a load/store requester (0) and a
// fetch/DMA requester (1). Hits complete in the granting cycle; a miss is
// replayed from holding registers until the memory system releases its stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_stall,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_stall,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state, w_state_d;
    logic              r_owner, w_owner_d;
    logic              r_prio, w_prio_d;
    op_e               r_hold_op, w_hold_op_d;
    logic [ADDR_W-1:0] r_hold_addr, w_hold_addr_d;
    logic [DATA_W-1:0] r_hold_wdata, w_hold_wdata_d;

    logic              w_req0;
    logic              w_req1;
    logic              w_mode;
    logic              w_valid;
    logic              w_gnt;
    op_e               w_gop;
    logic [ADDR_W-1:0] w_gaddr;
    logic [DATA_W-1:0] w_gwdata;

    assign w_req0 = r0_read | r0_write;
    assign w_req1 = r1_read | r1_write;
    assign w_mode = (ROUND_ROBIN != 0);

    rr_arb2 u_rr_arb2 (
        .i_req0  (w_req0),
        .i_req1  (w_req1),
        .i_prio  (r_prio),
        .i_mode  (w_mode),
        .o_valid (w_valid),
        .o_gnt   (w_gnt)
    );

    // Select the granted requester's access for the IDLE fast path.
    always_comb begin
        w_gop    = w_gnt ? decode_op(r1_read, r1_write) : decode_op(r0_read, r0_write);
        w_gaddr  = w_gnt ? r1_addr : r0_addr;
        w_gwdata = w_gnt ? r1_wdata : r0_wdata;
    end

    // Next-state and downstream/stall outputs; reset forces the bus quiet.
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        r0_stall       = w_req0;
        r1_stall       = w_req1;
        rdata          = mem_rdata;
        w_state_d      = r_state;
        w_owner_d      = r_owner;
        w_prio_d       = r_prio;
        w_hold_op_d    = r_hold_op;
        w_hold_addr_d  = r_hold_addr;
        w_hold_wdata_d = r_hold_wdata;

        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        mem_read  = (w_gop == OP_RD);
                        mem_write = (w_gop == OP_WR);
                        mem_addr  = w_gaddr;
                        mem_wdata = w_gwdata;
                        // Loser keeps its default stall (= its request).
                        if (w_gnt) begin
                            r1_stall = mem_stall;
                        end else begin
                            r0_stall = mem_stall;
                        end
                        if (mem_stall) begin
                            w_hold_op_d    = w_gop;
                            w_hold_addr_d  = w_gaddr;
                            w_hold_wdata_d = w_gwdata;
                            w_owner_d      = w_gnt;
                            w_state_d      = ST_BUSY;
                        end else if (w_mode) begin
                            w_prio_d = ~w_gnt;
                        end
                    end
                end
                ST_BUSY: begin
                    // Requester inputs are ignored until the held access ends.
                    mem_read  = (r_hold_op == OP_RD);
                    mem_write = (r_hold_op == OP_WR);
                    mem_addr  = r_hold_addr;
                    mem_wdata = r_hold_wdata;
                    if (r_owner) begin
                        r1_stall = mem_stall;
                    end else begin
                        r0_stall = mem_stall;
                    end
                    if (!mem_stall) begin
                        w_state_d = ST_IDLE;
                        if (w_mode) begin
                            w_prio_d = ~r_owner;
                        end
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, arbitration and holding registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_prio       <= 1'b0;
            r_hold_op    <= OP_NONE;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_prio       <= w_prio_d;
            r_hold_op    <= w_hold_op_d;
            r_hold_addr  <= w_hold_addr_d;
            r_hold_wdata <= w_hold_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected outputs are queued as each
// step is driven and compared at the following falling edge. A second
// instance with fixed priority shares the inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [9:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;

    logic        r0_stall, r1_stall, mem_read, mem_write;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, rdata;

    logic        d2_r0_stall, d2_r1_stall, d2_mem_read, d2_mem_write;
    logic [9:0]  d2_mem_addr;
    logic [31:0] d2_mem_wdata, d2_rdata;

    int errors = 0;
    int checks = 0;
    bit chk_d2 = 1'b0;

    typedef struct {
        string       tag;
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        s0;
        logic        s1;
        bit          chk_bus;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_stall(r0_stall),
        .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_stall(r1_stall),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_stall(d2_r0_stall),
        .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_stall(d2_r1_stall),
        .rdata(d2_rdata), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
        .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata), .mem_stall(mem_stall),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue the expectation for this cycle, then compare at the falling edge.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input logic s0, input logic s1, input bit chk_bus);
        exp_t e;
        exp_t got;
        e.tag = tag; e.rd = rd; e.wr = wr; e.addr = addr; e.wd = wd;
        e.s0 = s0; e.s1 = s1; e.chk_bus = chk_bus;
        exp_q.push_back(e);
        mem_rdata = $urandom;
        @(negedge clk);
        got = exp_q.pop_front();
        chk({got.tag, ".mem_read"}, 32'(mem_read), 32'(got.rd));
        chk({got.tag, ".mem_write"}, 32'(mem_write), 32'(got.wr));
        chk({got.tag, ".r0_stall"}, 32'(r0_stall), 32'(got.s0));
        chk({got.tag, ".r1_stall"}, 32'(r1_stall), 32'(got.s1));
        chk({got.tag, ".rdata"}, rdata, mem_rdata);
        if (got.chk_bus) begin
            chk({got.tag, ".mem_addr"}, 32'(mem_addr), 32'(got.addr));
            chk({got.tag, ".mem_wdata"}, mem_wdata, got.wd);
        end
        if (chk_d2) begin
            chk({got.tag, ".fixed.mem_read"}, 32'(d2_mem_read), 32'd1);
            chk({got.tag, ".fixed.mem_addr"}, 32'(d2_mem_addr), 32'h010);
            chk({got.tag, ".fixed.r0_stall"}, 32'(d2_r0_stall), 32'd0);
            chk({got.tag, ".fixed.r1_stall"}, 32'(d2_r1_stall), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r0_read = 1'b1; r0_write = 1'b0; r0_addr = 10'h005; r0_wdata = 32'h0;
        r1_read = 1'b0; r1_write = 1'b0; r1_addr = 10'h000; r1_wdata = 32'h0;
        mem_stall = 1'b0; mem_rdata = 32'h0;

        // Reset held two cycles with a pending read.
        step("rst_c1", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b1);
        step("rst_c2", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b1);

        // Both read continuously, all hits: r0 first (prio reset to 0), then alternate.
        rst = 1'b0;
        r0_read = 1'b1; r0_addr = 10'h010; r0_wdata = 32'h1111_0000;
        r1_read = 1'b1; r1_addr = 10'h020; r1_wdata = 32'h2222_0000;
        step("rr_c1", 1'b1, 1'b0, 10'h010, 32'h1111_0000, 1'b0, 1'b1, 1'b1);
        step("rr_c2", 1'b1, 1'b0, 10'h020, 32'h2222_0000, 1'b1, 1'b0, 1'b1);
        step("rr_c3", 1'b1, 1'b0, 10'h010, 32'h1111_0000, 1'b0, 1'b1, 1'b1);

        // Nobody requesting.
        r0_read = 1'b0; r1_read = 1'b0;
        step("idle", 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0);

        // Lone r0 read hit at 0x005.
        r0_read = 1'b1; r0_addr = 10'h005; r0_wdata = 32'h0;
        step("r0_hit", 1'b1, 1'b0, 10'h005, 32'h0, 1'b0, 1'b0, 1'b1);

        // Read and write together resolve to a write.
        r0_write = 1'b1; r0_addr = 10'h007; r0_wdata = 32'hA5A5_A5A5;
        step("r0_rw", 1'b0, 1'b1, 10'h007, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1);

        // r1 write miss for 4 cycles while r0 keeps reading; prio now favours r1.
        r0_write = 1'b0; r0_addr = 10'h055; r0_wdata = 32'h0;
        r1_write = 1'b1; r1_addr = 10'h3FF; r1_wdata = 32'hDEAD_BEEF;
        mem_stall = 1'b1;
        step("miss_c1", 1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        r1_addr = 10'h001; r1_wdata = 32'h1234_5678;
        step("miss_c2", 1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        step("miss_c3", 1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        step("miss_c4", 1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        mem_stall = 1'b0;
        step("miss_c5", 1'b0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);

        // No back-to-back grant happened; r0 is served next from its own inputs.
        r1_write = 1'b0;
        step("post_miss", 1'b1, 1'b0, 10'h055, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset in the second cycle of an r0 miss.
        r0_addr = 10'h0AA; mem_stall = 1'b1;
        step("rstm_c1", 1'b1, 1'b0, 10'h0AA, 32'h0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; r0_addr = 10'h0BB;
        step("rstm_c2", 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b1);
        // Fresh grant after reset: prio is back to 0, so r0 wins the tie.
        rst = 1'b0; mem_stall = 1'b0;
        r1_read = 1'b1; r1_addr = 10'h0CC; r1_wdata = 32'h0;
        step("rstm_c3", 1'b1, 1'b0, 10'h0BB, 32'h0, 1'b0, 1'b1, 1'b1);

        // Continuous contention: round-robin alternates, fixed priority always picks r0.
        r0_addr = 10'h010; r0_wdata = 32'h1111_0000;
        r1_addr = 10'h020; r1_wdata = 32'h2222_0000;
        chk_d2 = 1'b1;
        step("cont_c1", 1'b1, 1'b0, 10'h020, 32'h2222_0000, 1'b1, 1'b0, 1'b1);
        step("cont_c2", 1'b1, 1'b0, 10'h010, 32'h1111_0000, 1'b0, 1'b1, 1'b1);
        step("cont_c3", 1'b1, 1'b0, 10'h020, 32'h2222_0000, 1'b1, 1'b0, 1'b1);
        step("cont_c4", 1'b1, 1'b0, 10'h010, 32'h1111_0000, 1'b0, 1'b1, 1'b1);
        chk_d2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
